// File: rtl/shifter_reg_pkg.sv
// Shared constants for the shifter_reg slice.
// ENABLE/DISABLE/HIGH/LOW are the build-option values used by every ParamMod
// block parameter, kept as typed localparams so they import like any other name.
package shifter_reg_pkg;
  localparam bit ENABLE  = 1'b1;
  localparam bit DISABLE = 1'b0;
  localparam bit HIGH    = 1'b1;
  localparam bit LOW     = 1'b0;

  // Shift-amount field width as seen on the port: one-hot vectors span the
  // data word, binary amounts use SHAMT bits.
  function automatic int sw_of(input bit bit_vec, input int data, input int shamt);
    return bit_vec ? data : shamt;
  endfunction
endpackage

// File: rtl/shifter_reg_if.sv
// Request/result bundle for shifter_reg.
//   in_valid/in/shamt : request, driven by the master
//   out_valid/out     : registered result, driven by the slave (shifter_reg)
// DATA and SW must match the parameters of the attached shifter_reg.
interface shifter_reg_if #(
  parameter int DATA = 8,
  parameter int SW   = 3
);
  logic            in_valid;
  logic [DATA-1:0] in;
  logic [SW-1:0]   shamt;
  logic            out_valid;
  logic [DATA-1:0] out;

  modport master (output in_valid, in, shamt, input  out_valid, out);
  modport slave  (input  in_valid, in, shamt, output out_valid, out);
endinterface

// File: rtl/shifter_reg_core.sv
// shifter_core: combinational shift/rotate datapath.
//   din   : operand
//   shamt : shift amount, binary (SHAMT bits) or one-hot (DATA bits)
//   dout  : shifted / rotated operand
// The amount is reduced to a binary index, then applied through a log2 mux
// barrel. Each stage k moves the word by 2^k; in rotate mode that move is
// taken mod DATA, so the composed rotation is (n mod DATA) without a divider.
module shifter_core
  import shifter_reg_pkg::*;
#(
  parameter bit BIT_VEC  = DISABLE,
  parameter bit ROTATE   = ENABLE,
  parameter bit TO_RIGHT = DISABLE,
  parameter int DATA     = 8,
  parameter int SHAMT    = 3,
  parameter bit ACT      = HIGH,
  localparam int SW      = sw_of(BIT_VEC, DATA, SHAMT)
) (
  input  logic [DATA-1:0] din,
  input  logic [SW-1:0]   shamt,
  output logic [DATA-1:0] dout
);
  localparam int AW = BIT_VEC ? $clog2(DATA) : SHAMT;

  logic [AW-1:0] amt;

  if (BIT_VEC) begin : g_onehot
    // Priority encoder: scanning high to low lets the lowest active bit win.
    // No active bit leaves amt at zero.
    always_comb begin
      amt = '0;
      for (int i = DATA-1; i >= 0; i--)
        if (shamt[i] == ACT) amt = AW'(i);
    end
  end else begin : g_bin
    assign amt = shamt;
  end

  logic [AW:0][DATA-1:0] stg;
  assign stg[0] = din;

  for (genvar k = 0; k < AW; k++) begin : g_stage
    localparam int STEP = ROTATE ? ((2**k) % DATA) : (2**k);
    logic [DATA-1:0] moved;

    if (STEP == 0) begin : g_id
      assign moved = stg[k];
    end else if (!ROTATE && STEP >= DATA) begin : g_zero
      assign moved = '0;
    end else if (ROTATE && TO_RIGHT) begin : g_rr
      assign moved = (stg[k] >> STEP) | (stg[k] << (DATA-STEP));
    end else if (ROTATE) begin : g_rl
      assign moved = (stg[k] << STEP) | (stg[k] >> (DATA-STEP));
    end else if (TO_RIGHT) begin : g_sr
      assign moved = stg[k] >> STEP;
    end else begin : g_sl
      assign moved = stg[k] << STEP;
    end

    assign stg[k+1] = amt[k] ? moved : stg[k];
  end

  assign dout = stg[AW];
endmodule

// File: rtl/shifter_reg.sv
// shifter_reg: registered barrel shifter/rotator, one-cycle latency.
//   clk    : rising-edge clock
//   reset_ : asynchronous active-low reset, clears out and out_valid
//   bus    : slave side of shifter_reg_if (in_valid/in/shamt -> out_valid/out)
// A valid request is always accepted; out holds its last result while idle
// and out_valid only marks the cycle after a capture.
module shifter_reg
  import shifter_reg_pkg::*;
#(
  parameter bit BIT_VEC  = DISABLE,
  parameter bit ROTATE   = ENABLE,
  parameter bit TO_RIGHT = DISABLE,
  parameter int DATA     = 8,
  parameter int SHAMT    = 3,
  parameter bit ACT      = HIGH
) (
  input  logic         clk,
  input  logic         reset_,
  shifter_reg_if.slave bus
);
  logic [DATA-1:0] res;

  shifter_core #(
    .BIT_VEC (BIT_VEC),
    .ROTATE  (ROTATE),
    .TO_RIGHT(TO_RIGHT),
    .DATA    (DATA),
    .SHAMT   (SHAMT),
    .ACT     (ACT)
  ) u_core (
    .din  (bus.in),
    .shamt(bus.shamt),
    .dout (res)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.out <= res;
    end
  end
endmodule

// File: tb/tb_shifter_reg.sv
// Bench for shifter_reg: six instances with different build options share
// clk/reset/in_valid/in; each gets its own shift amount. Expected results come
// from an index-arithmetic reference model of the shift/rotate rules.
module tb_shifter_reg;
  import shifter_reg_pkg::*;

  // Instance configs: 0 rot-left SHAMT3, 1 logical-left SHAMT4,
  // 2 logical-right SHAMT3, 3 rot-right SHAMT4, 4 one-hot ACT high, 5 one-hot ACT low
  localparam bit ROT [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam bit RT  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam bit BV  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam bit AV  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam int SHW [6] = '{3, 4, 3, 4, 8, 8};

  logic       clk = 1'b0;
  logic       reset_;
  logic       in_valid;
  logic [7:0] din;
  logic [7:0] sh [6];
  logic [7:0] o  [6];
  logic       ov [6];
  logic [7:0] exp_o [6];
  logic       exp_v;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  shifter_reg_if #(.DATA(8), .SW(3)) if0 ();
  shifter_reg_if #(.DATA(8), .SW(4)) if1 ();
  shifter_reg_if #(.DATA(8), .SW(3)) if2 ();
  shifter_reg_if #(.DATA(8), .SW(4)) if3 ();
  shifter_reg_if #(.DATA(8), .SW(8)) if4 ();
  shifter_reg_if #(.DATA(8), .SW(8)) if5 ();

  assign if0.in_valid = in_valid; assign if0.in = din; assign if0.shamt = sh[0][2:0];
  assign if1.in_valid = in_valid; assign if1.in = din; assign if1.shamt = sh[1][3:0];
  assign if2.in_valid = in_valid; assign if2.in = din; assign if2.shamt = sh[2][2:0];
  assign if3.in_valid = in_valid; assign if3.in = din; assign if3.shamt = sh[3][3:0];
  assign if4.in_valid = in_valid; assign if4.in = din; assign if4.shamt = sh[4];
  assign if5.in_valid = in_valid; assign if5.in = din; assign if5.shamt = sh[5];

  assign o[0] = if0.out; assign ov[0] = if0.out_valid;
  assign o[1] = if1.out; assign ov[1] = if1.out_valid;
  assign o[2] = if2.out; assign ov[2] = if2.out_valid;
  assign o[3] = if3.out; assign ov[3] = if3.out_valid;
  assign o[4] = if4.out; assign ov[4] = if4.out_valid;
  assign o[5] = if5.out; assign ov[5] = if5.out_valid;

  shifter_reg #(.BIT_VEC(DISABLE), .ROTATE(ENABLE),  .TO_RIGHT(DISABLE), .DATA(8), .SHAMT(3), .ACT(HIGH))
    u_d0 (.clk(clk), .reset_(reset_), .bus(if0));
  shifter_reg #(.BIT_VEC(DISABLE), .ROTATE(DISABLE), .TO_RIGHT(DISABLE), .DATA(8), .SHAMT(4), .ACT(HIGH))
    u_d1 (.clk(clk), .reset_(reset_), .bus(if1));
  shifter_reg #(.BIT_VEC(DISABLE), .ROTATE(DISABLE), .TO_RIGHT(ENABLE),  .DATA(8), .SHAMT(3), .ACT(HIGH))
    u_d2 (.clk(clk), .reset_(reset_), .bus(if2));
  shifter_reg #(.BIT_VEC(DISABLE), .ROTATE(ENABLE),  .TO_RIGHT(ENABLE),  .DATA(8), .SHAMT(4), .ACT(HIGH))
    u_d3 (.clk(clk), .reset_(reset_), .bus(if3));
  shifter_reg #(.BIT_VEC(ENABLE),  .ROTATE(ENABLE),  .TO_RIGHT(DISABLE), .DATA(8), .SHAMT(3), .ACT(HIGH))
    u_d4 (.clk(clk), .reset_(reset_), .bus(if4));
  shifter_reg #(.BIT_VEC(ENABLE),  .ROTATE(ENABLE),  .TO_RIGHT(DISABLE), .DATA(8), .SHAMT(3), .ACT(LOW))
    u_d5 (.clk(clk), .reset_(reset_), .bus(if5));

  // Reference: derive the amount n, then place bits by index arithmetic.
  function automatic logic [7:0] model(input int k, input logic [7:0] d, input logic [7:0] s);
    int n;
    bit found;
    logic [7:0] r;
    n = 0;
    found = 0;
    if (BV[k]) begin
      for (int i = 0; i < 8; i++)
        if (!found && s[i] == AV[k]) begin n = i; found = 1; end
    end else begin
      n = int'(s) % (1 << SHW[k]);
    end
    if (ROT[k]) begin
      n = n % 8;
      for (int i = 0; i < 8; i++)
        r[i] = RT[k] ? d[(i + n) % 8] : d[(i - n + 8) % 8];
    end else if (n >= 8) begin
      r = 8'h00;
    end else begin
      r = RT[k] ? (d >> n) : (d << n);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic cyc();
    @(posedge clk);
    if (!reset_) begin
      for (int k = 0; k < 6; k++) exp_o[k] = 8'h00;
      exp_v = 1'b0;
    end else begin
      if (in_valid)
        for (int k = 0; k < 6; k++) exp_o[k] = model(k, din, sh[k]);
      exp_v = in_valid;
    end
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("out%0d", k), o[k], exp_o[k]);
      chk($sformatf("out_valid%0d", k), {7'b0, ov[k]}, {7'b0, exp_v});
    end
  endtask

  task automatic rand_inputs();
    din = 8'($urandom);
    for (int k = 0; k < 6; k++) sh[k] = 8'($urandom);
  endtask

  initial begin
    reset_ = 1'b0;
    in_valid = 1'b1;
    rand_inputs();

    // Reset held across edges with a pending request
    cyc();
    cyc();
    #2 reset_ = 1'b1;

    // Directed sweep; literal spec values on the relevant instances
    din = 8'b10011100;
    for (int i = 0; i < 8; i++) begin
      sh[0] = 8'(i);
      sh[1] = (i == 0) ? 8'd3 : (i == 1) ? 8'd9 : 8'($urandom);
      sh[2] = (i == 0) ? 8'd2 : 8'($urandom);
      sh[3] = (i == 0) ? 8'd3 : (i == 1) ? 8'd11 : 8'($urandom);
      sh[4] = (i == 0) ? 8'b00000100 : (i == 1) ? 8'b00010100 : (i == 2) ? 8'h00 : 8'($urandom);
      sh[5] = (i == 0) ? 8'b11111011 : 8'($urandom);
      cyc();
      if (i == 0) begin
        chk("rotl_n0", o[0], 8'b10011100);
        chk("shl_n3", o[1], 8'b11100000);
        chk("shr_n2", o[2], 8'b00100111);
        chk("rotr_n3", o[3], 8'b10010011);
        chk("onehot_bit2", o[4], 8'b01110010);
        chk("onehot_low", o[5], 8'b01110010);
      end
      if (i == 1) begin
        chk("rotl_n1", o[0], 8'b00111001);
        chk("shl_n9", o[1], 8'b00000000);
        chk("rotr_n11", o[3], 8'b10010011);
        chk("onehot_lowest", o[4], 8'b01110010);
      end
      if (i == 2) chk("onehot_none", o[4], 8'b10011100);
      if (i == 3) chk("rotl_n3", o[0], 8'b11100100);
      if (i == 7) chk("rotl_n7", o[0], 8'b01001110);
    end

    // Hold: idle cycles with changing inputs keep the last result
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cyc();
      chk("hold_rotl", o[0], 8'b01001110);
    end

    // Random traffic with random gaps
    for (int i = 0; i < 60; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      rand_inputs();
      cyc();
    end

    // Asynchronous reset between edges discards the result at once
    in_valid = 1'b1;
    rand_inputs();
    cyc();
    #3 reset_ = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("async_rst_out%0d", k), o[k], 8'h00);
      chk($sformatf("async_rst_vld%0d", k), {7'b0, ov[k]}, 8'h00);
    end
    rand_inputs();
    cyc();
    reset_ = 1'b1;

    // Recovery after reset
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
